// File: rtl/q_max_sequencer.sv
// q_max_sequencer: scans the N_ACT Q-values of one state, reports the max and its lowest argmax
module q_max_sequencer #(
    parameter int Q_W   = 16,
    parameter int N_ACT = 9,
    parameter int S_W   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [S_W-1:0] state_idx,
    output logic           busy,
    output logic           rd_en,
    output logic [S_W+3:0] rd_addr,
    input  logic [Q_W-1:0] rd_data,
    output logic           done,
    output logic [Q_W-1:0] max_q,
    output logic [3:0]     max_act
);
    localparam logic [3:0] LAST = 4'(N_ACT - 1);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t         state, state_d;
    logic [S_W-1:0] idx, idx_d;
    logic [3:0]     act, act_d, v_act, acc_act, cur_act;
    logic           v, take, busy_d, rd_en_d, done_d;
    logic [S_W+3:0] rd_addr_d;
    logic [Q_W-1:0] acc_q, cur_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            act     <= '0;
            v       <= 1'b0;
            v_act   <= '0;
            acc_q   <= '0;
            acc_act <= '0;
            busy    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            done    <= 1'b0;
            max_q   <= '0;
            max_act <= '0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            act     <= act_d;
            v       <= rd_en;
            v_act   <= rd_addr[3:0];
            acc_q   <= cur_q;
            acc_act <= cur_act;
            busy    <= busy_d;
            rd_en   <= rd_en_d;
            rd_addr <= rd_addr_d;
            done    <= done_d;
            if (done_d) begin
                max_q   <= cur_q;
                max_act <= cur_act;
            end
        end
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? READ : IDLE;
            READ:    state_d = (act == LAST) ? DRAIN : READ;
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are computed from the next state so they can be registered without a cycle of lag.
    always_comb begin
        rd_en_d   = state_d == READ;
        busy_d    = state_d != IDLE;
        done_d    = state_d == DONE;
        act_d     = (state == READ && rd_en_d) ? act + 4'd1 : 4'd0;
        idx_d     = (state == IDLE && start) ? state_idx : idx;
        rd_addr_d = rd_en_d ? {idx_d, act_d} : '0;
        take      = v && (v_act == 4'd0 || rd_data > acc_q);
        cur_q     = take ? rd_data : acc_q;
        cur_act   = take ? v_act : acc_act;
    end
endmodule

// File: doc/q_max_sequencer.md
Q_MAX_SEQUENCER -- requirements
Module: q_max_sequencer

Interface
REQ-001 Parameter Q_W, 16, Q-value width in bits; values are unsigned.
REQ-002 Parameter N_ACT, 9, number of actions per state; legal range 2..16.
REQ-003 Parameter S_W, 8, state-index width.
REQ-004 The block SHALL use one clock, clk, and a synchronous, active-low reset, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 start  input  1  request a max search for state_idx; sampled only in IDLE.
REQ-008 state_idx  input  S_W  state whose N_ACT Q-values are scanned; captured when start is accepted.
REQ-009 busy  output  1  high from the cycle after start is accepted until done is high, inclusive.
REQ-010 rd_en  output  1  Q-table read strobe.
REQ-011 rd_addr  output  S_W+4  read address {captured state_idx, action[3:0]}.
REQ-012 rd_data  input  Q_W  Q-table data, valid exactly 1 cycle after rd_en (fixed latency).
REQ-013 done  output  1  one-cycle pulse; max_q and max_act are valid.
REQ-014 max_q  output  Q_W  maximum Q-value of the last completed search.
REQ-015 max_act  output  4  action index of max_q.

Function
REQ-016 FSM states SHALL be IDLE, READ, DRAIN and DONE.
REQ-017 IDLE->READ SHALL occur when start=1 at edge T; state_idx is latched and the action counter is cleared.
REQ-018 In READ, rd_en SHALL be 1 for exactly N_ACT consecutive cycles (T+1..T+N_ACT), with action = 0..N_ACT-1 ascending, one per cycle.
REQ-019 READ->DRAIN SHALL occur after the issue of action N_ACT-1; DRAIN SHALL last 1 cycle while the last rd_data is consumed.
REQ-020 DRAIN->DONE->IDLE: done SHALL be 1 for exactly 1 cycle, at T+N_ACT+2 (T+11 for N_ACT=9).
REQ-021 The running max SHALL be initialised from the action-0 data, not from zero.
REQ-022 Running max and argmax SHALL update only when rd_data > current max (strict unsigned compare); ties keep the lower action index.
REQ-023 max_q and max_act SHALL update only in the cycle done rises, and SHALL hold until the next done.
REQ-024 rd_data SHALL be ignored in every cycle not exactly 1 cycle after an rd_en.
REQ-025 start SHALL be ignored while busy=1; no queuing.
REQ-026 start=1 on the cycle done=1 SHALL be ignored; start at DONE+1 (IDLE) SHALL be accepted.
REQ-027 rd_addr SHALL be 0 whenever rd_en=0.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-029 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE, and busy, rd_en, rd_addr, done, max_q and max_act SHALL all be 0.
REQ-030 Reset mid-search SHALL abandon the search with no done pulse; the data in flight is discarded.
REQ-031 The first start after rst_n returns to 1 SHALL be accepted normally.

Verification
REQ-032 Q = {5,9,3,9,1,0,2,8,7}, state_idx=0x12, start at T -> rd_addr 0x120..0x128 on T+1..T+9; done at T+11 with max_q=9, max_act=1.
REQ-033 All nine Q-values = 0x0000 -> max_q=0, max_act=0; all nine = 0xFFFF -> max_q=0xFFFF, max_act=0.
REQ-034 Q = {1,2,3,4,5,6,7,8,0x8000} -> max_q=0x8000, max_act=8 (unsigned compare, last action wins).
REQ-035 start pulsed at T+3 and on the done cycle -> ignored, with exactly one done; start at done+1 -> a second search with rd_en on the next cycle.
REQ-036 rst_n=0 at T+5 of a search -> all outputs 0 on the next cycle, no done pulse, and max_q/max_act stay 0 until a new search completes.
REQ-037 Random Q-tables, at least 1000 searches, checked against a reference model -> max_q and lowest-index argmax match, with done at a fixed latency of N_ACT+2.
